// File: rtl/hdmi_tx_timing_ctrl.sv
// Video timing generator for the HDMI TX path: sync/de, TMDS preamble and guard band, pixel coordinates.
// All outputs registered one cycle after the h/v position; start and stop only happen on frame boundaries.
module hdmi_tx_timing_ctrl #(
   parameter int H_ACTIVE = 1280,
   parameter int H_FP     = 110,
   parameter int H_SYNC   = 40,
   parameter int H_BP     = 220,
   parameter int V_ACTIVE = 720,
   parameter int V_FP     = 5,
   parameter int V_SYNC   = 5,
   parameter int V_BP     = 20,
   parameter bit HS_POL   = 1'b1,
   parameter bit VS_POL   = 1'b1,
   parameter int PRE_LEN  = 8,
   parameter int GB_LEN   = 2
) (
   input  logic        i_pixclk,
   input  logic        i_reset_n,
   input  logic        i_enable,
   output logic        o_hsync,
   output logic        o_vsync,
   output logic        o_de,
   output logic [3:0]  o_ctrl,
   output logic        o_guard,
   output logic        o_pix_req,
   output logic [11:0] o_x,
   output logic [11:0] o_y,
   output logic        o_frame_start,
   output logic        o_busy
);

   localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

   localparam logic [11:0] H_ACT_END  = 12'(H_ACTIVE);
   localparam logic [11:0] H_ACT_LAST = 12'(H_ACTIVE - 1);
   localparam logic [11:0] H_HS_BEG   = 12'(H_ACTIVE + H_FP);
   localparam logic [11:0] H_HS_END   = 12'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [11:0] H_PRE_BEG  = 12'(H_TOTAL - PRE_LEN - GB_LEN);
   localparam logic [11:0] H_GB_BEG   = 12'(H_TOTAL - GB_LEN);
   localparam logic [11:0] H_LAST     = 12'(H_TOTAL - 1);
   localparam logic [11:0] V_ACT_END  = 12'(V_ACTIVE);
   localparam logic [11:0] V_ACT_LAST = 12'(V_ACTIVE - 1);
   localparam logic [11:0] V_VS_BEG   = 12'(V_ACTIVE + V_FP);
   localparam logic [11:0] V_VS_END   = 12'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic [11:0] V_LAST     = 12'(V_TOTAL - 1);
   localparam logic [11:0] V_STOP     = 12'(V_TOTAL - 2);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

   state_t      state_q, state_d;
   logic [11:0] h_q, h_d, v_q, v_d;
   logic [11:0] h_nxt, v_nxt;

   logic        hsync_q, vsync_q, de_q, guard_q, pix_req_q, frame_start_q, busy_q;
   logic [3:0]  ctrl_q;
   logic [11:0] x_q, y_q;

   logic running, h_act, v_act, in_hs, in_vs, pre_line, in_pre, in_gb, req;

   always_comb begin
      h_nxt = (h_q == H_LAST) ? 12'd0 : h_q + 12'd1;
      v_nxt = v_q;
      if (h_q == H_LAST) begin
         v_nxt = (v_q == V_LAST) ? 12'd0 : v_q + 12'd1;
      end
   end

   always_comb begin
      state_d = state_q;
      h_d     = h_q;
      v_d     = v_q;
      case (state_q)
         S_IDLE: begin
            if (i_enable) begin
               state_d = S_RUN;
               h_d     = 12'd0;
               v_d     = V_LAST;
            end
         end
         S_RUN: begin
            h_d = h_nxt;
            v_d = v_nxt;
            if (!i_enable) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            h_d = h_nxt;
            v_d = v_nxt;
            // A re-enable wins over the end position so the frame continues without a gap.
            if (i_enable) begin
               state_d = S_RUN;
            end else if (h_q == H_LAST && v_q == V_STOP) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_ff @(posedge i_pixclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state_q <= S_IDLE;
         h_q     <= 12'd0;
         v_q     <= 12'd0;
      end else begin
         state_q <= state_d;
         h_q     <= h_d;
         v_q     <= v_d;
      end
   end

   assign running  = (state_q != S_IDLE);
   assign h_act    = (h_q < H_ACT_END);
   assign v_act    = (v_q < V_ACT_END);
   assign in_hs    = (h_q >= H_HS_BEG) && (h_q < H_HS_END);
   assign in_vs    = (v_q >= V_VS_BEG) && (v_q < V_VS_END);
   assign pre_line = (v_q == V_LAST) || (v_q < V_ACT_LAST);
   assign in_pre   = pre_line && (h_q >= H_PRE_BEG) && (h_q < H_GB_BEG);
   assign in_gb    = pre_line && (h_q >= H_GB_BEG);
   // Request mirrors de at the next position: rest of an active line, or the wrap into an active line.
   assign req      = (v_act && (h_q < H_ACT_LAST)) || (pre_line && (h_q == H_LAST));

   always_ff @(posedge i_pixclk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         hsync_q       <= ~HS_POL;
         vsync_q       <= ~VS_POL;
         de_q          <= 1'b0;
         ctrl_q        <= 4'b0000;
         guard_q       <= 1'b0;
         pix_req_q     <= 1'b0;
         x_q           <= 12'd0;
         y_q           <= 12'd0;
         frame_start_q <= 1'b0;
         busy_q        <= 1'b0;
      end else begin
         hsync_q       <= (running && in_hs) ? HS_POL : ~HS_POL;
         vsync_q       <= (running && in_vs) ? VS_POL : ~VS_POL;
         de_q          <= running && h_act && v_act;
         ctrl_q        <= (running && in_pre) ? 4'b0001 : 4'b0000;
         guard_q       <= running && in_gb;
         pix_req_q     <= running && req;
         x_q           <= running ? h_q : 12'd0;
         y_q           <= running ? v_q : 12'd0;
         frame_start_q <= running && (h_q == 12'd0) && (v_q == 12'd0);
         busy_q        <= running;
      end
   end

   assign o_hsync       = hsync_q;
   assign o_vsync       = vsync_q;
   assign o_de          = de_q;
   assign o_ctrl        = ctrl_q;
   assign o_guard       = guard_q;
   assign o_pix_req     = pix_req_q;
   assign o_x           = x_q;
   assign o_y           = y_q;
   assign o_frame_start = frame_start_q;
   assign o_busy        = busy_q;

endmodule

// File: tb/tb_hdmi_tx_timing_ctrl.sv
// Bench for hdmi_tx_timing_ctrl on a small 33x9 raster; reference model works on a linear frame position.
module tb_hdmi_tx_timing_ctrl;

   localparam int HA = 16, HFP = 2, HSW = 3, HBP = 12;
   localparam int VA = 4, VFP = 1, VSW = 2, VBP = 2;
   localparam int PRE = 8, GB = 2;
   localparam int HT = HA + HFP + HSW + HBP;
   localparam int VT = VA + VFP + VSW + VBP;
   localparam int FT = HT * VT;
   localparam int END_P = FT - HT - 1;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        en = 1'b0;
   logic        o_hsync, o_vsync, o_de, o_guard, o_pix_req, o_frame_start, o_busy;
   logic [3:0]  o_ctrl;
   logic [11:0] o_x, o_y;

   always #5 clk = ~clk;

   hdmi_tx_timing_ctrl #(
      .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
      .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
      .HS_POL(1'b1), .VS_POL(1'b1), .PRE_LEN(PRE), .GB_LEN(GB)
   ) dut (
      .i_pixclk(clk), .i_reset_n(rst_n), .i_enable(en),
      .o_hsync(o_hsync), .o_vsync(o_vsync), .o_de(o_de), .o_ctrl(o_ctrl),
      .o_guard(o_guard), .o_pix_req(o_pix_req), .o_x(o_x), .o_y(o_y),
      .o_frame_start(o_frame_start), .o_busy(o_busy)
   );

   typedef struct packed {
      logic        hs, vs, de;
      logic [3:0]  ctrl;
      logic        guard, req;
      logic [11:0] x, y;
      logic        fs, busy;
   } obs_t;

   int tests = 0, fails = 0;
   bit m_live = 1'b0;
   bit m_prev_en = 1'b0;
   int m_p = 0;
   int n_de, n_req, n_fs, n_hs, n_vs, n_pre, n_gb, cnt;
   bit busy_low;

   function automatic bit de_at(int p);
      return ((p % HT) < HA) && ((p / HT) < VA);
   endfunction

   // Expected outputs for one frame position, straight from the raster rules.
   function automatic obs_t model_out(bit live, int p);
      obs_t o;
      int h, v, nl;
      h  = p % HT;
      v  = p / HT;
      nl = (v + 1) % VT;
      o  = '0;
      if (live) begin
         o.hs    = (h >= HA + HFP) && (h < HA + HFP + HSW);
         o.vs    = (v >= VA + VFP) && (v < VA + VFP + VSW);
         o.de    = de_at(p);
         o.ctrl  = (nl < VA && h >= HT - PRE - GB && h < HT - GB) ? 4'b0001 : 4'b0000;
         o.guard = (nl < VA) && (h >= HT - GB);
         o.req   = de_at((p + 1) % FT);
         o.x     = o.de ? 12'(h) : 12'd0;
         o.y     = o.de ? 12'(v) : 12'd0;
         o.fs    = (p == 0);
         o.busy  = 1'b1;
      end
      return o;
   endfunction

   function automatic obs_t sample();
      obs_t o;
      o = {o_hsync, o_vsync, o_de, o_ctrl, o_guard, o_pix_req,
           o_de ? o_x : 12'd0, o_de ? o_y : 12'd0, o_frame_start, o_busy};
      return o;
   endfunction

   task automatic check(input string tag, input longint got, input longint exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      obs_t exp;
      @(posedge clk);
      exp = model_out(m_live, m_p);
      if (!rst_n) begin
         m_live = 1'b0;
         m_p    = 0;
      end else if (!m_live) begin
         if (en) begin
            m_live = 1'b1;
            m_p    = FT - HT;
         end
      end else begin
         if (!en && !m_prev_en && m_p == END_P) m_live = 1'b0;
         m_p = (m_p + 1) % FT;
      end
      m_prev_en = en;
      #1;
      check("cycle", longint'(sample()), longint'(exp));
      n_de  += int'(o_de);
      n_req += int'(o_pix_req);
      n_fs  += int'(o_frame_start);
      n_hs  += int'(o_hsync);
      n_vs  += int'(o_vsync);
   endtask

   task automatic async_reset();
      #2;
      rst_n  = 1'b0;
      m_live = 1'b0;
      m_p    = 0;
      #1;
      check("async_rst", longint'(sample()), 64'd0);
   endtask

   task automatic run_to(input int target);
      for (int i = 0; i < 2 * FT && !(m_live && m_p == target); i++) tick();
      check("reach_pos", m_p, target);
   endtask

   task automatic clear_counts();
      n_de = 0; n_req = 0; n_fs = 0; n_hs = 0; n_vs = 0;
   endtask

   initial begin
      clear_counts();
      #1;
      check("reset_init", longint'(sample()), 64'd0);
      for (int i = 0; i < 3; i++) tick();
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) tick();

      // Two full frames of geometry.
      en = 1'b1;
      clear_counts();
      for (int i = 0; i < 1 + 2 * FT; i++) tick();
      check("frame_de", n_de, 2 * VA * HA);
      check("frame_req", n_req, 2 * VA * HA);
      check("frame_fs", n_fs, 2);
      check("frame_hs", n_hs, 2 * VT * HSW);
      check("frame_vs", n_vs, 2 * VSW * HT);

      // Clean stop mid active line 2.
      run_to(2 * HT + 5);
      en  = 1'b0;
      cnt = 0;
      do begin
         tick();
         cnt++;
      end while (o_busy && cnt < 1000);
      check("stop_lat", cnt, END_P - (2 * HT + 5) + 2);

      // Restart after an idle gap: preamble and guard precede the first frame start.
      for (int i = 0; i < 10; i++) tick();
      en = 1'b1;
      n_pre = 0; n_gb = 0; cnt = 0;
      do begin
         tick();
         cnt++;
         if (o_ctrl == 4'b0001) n_pre++;
         if (o_guard) n_gb++;
      end while (!o_frame_start && cnt < 1000);
      check("restart_lat", cnt, HT + 2);
      check("restart_pre", n_pre, PRE);
      check("restart_gb", n_gb, GB);

      // Abort stop: drop and re-raise enable inside the frame.
      run_to(3 * HT + 2);
      en = 1'b0;
      busy_low = 1'b0;
      for (int i = 0; i < 20; i++) begin
         tick();
         if (!o_busy) busy_low = 1'b1;
      end
      en = 1'b1;
      for (int i = 0; i < 5; i++) begin
         tick();
         if (!o_busy) busy_low = 1'b1;
      end
      check("abort_busy", busy_low, 0);

      // Re-enable exactly on the drain end position keeps the frame going.
      en = 1'b0;
      run_to(END_P);
      en = 1'b1;
      tick();
      tick();
      check("end_reenable", o_busy, 1);

      // Randomized enable toggling with occasional asynchronous resets.
      for (int i = 0; i < 4000; i++) begin
         if ($urandom_range(0, 99) < 4) en = ~en;
         if ($urandom_range(0, 999) < 3) begin
            async_reset();
            tick();
            tick();
            rst_n = 1'b1;
         end
         tick();
      end

      // Final async reset while running.
      en = 1'b1;
      for (int i = 0; i < 50; i++) tick();
      async_reset();
      tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/hdmi_tx_timing_ctrl.md
# hdmi_tx_timing_ctrl

Video timing controller that drives the HDMI TX encode/serialize path. Produces hsync/vsync/de, the 4-bit TMDS control word (video preamble) and a guard-band flag, plus pixel coordinates and a one-cycle-early pixel request for the upstream frame source. Runs in the pixel clock domain and feeds the TMDS encoder inputs directly. A start/stop sequencer guarantees that frames are only ever started or stopped on a frame boundary.

## Interface
Parameters:
- H_ACTIVE, 1280, active pixels per line
- H_FP, 110, horizontal front porch (pixels)
- H_SYNC, 40, hsync width (pixels)
- H_BP, 220, horizontal back porch (pixels); must be >= PRE_LEN+GB_LEN
- V_ACTIVE, 720, active lines per frame
- V_FP, 5, vertical front porch (lines)
- V_SYNC, 5, vsync width (lines)
- V_BP, 20, vertical back porch (lines); must be >= 1
- HS_POL, 1, hsync active level
- VS_POL, 1, vsync active level
- PRE_LEN, 8, video preamble length (pixels)
- GB_LEN, 2, video guard band length (pixels)

Ports:
- i_pixclk  in  1  pixel clock; the only clock
- i_reset_n  in  1  asynchronous, active-low reset
- i_enable  in  1  level request to run video timing
- o_hsync  out  1  horizontal sync, polarity HS_POL
- o_vsync  out  1  vertical sync, polarity VS_POL
- o_de  out  1  data enable (active video)
- o_ctrl  out  4  TMDS CTL[3:0]; 4'b0001 during video preamble, else 4'b0000
- o_guard  out  1  video guard band period
- o_pix_req  out  1  pixel request; equals o_de one cycle early
- o_x  out  12  pixel column; valid when o_de=1
- o_y  out  12  active line index; valid when o_de=1
- o_frame_start  out  1  one-cycle pulse on the first active pixel of a frame
- o_busy  out  1  1 in RUN or DRAIN

## Operation
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP and V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP. Both must be <= 4096.
- Internal 12-bit counters h (0..H_TOTAL-1) and v (0..V_TOTAL-1). h wraps to 0 and increments v. v wraps to 0 after V_TOTAL-1.
- Horizontal regions by h:
  - active: [0, H_ACTIVE)
  - front porch: [H_ACTIVE, H_ACTIVE+H_FP)
  - sync: next H_SYNC pixels
  - back porch: remainder of the line
- Vertical regions by v, in the same order: active, front porch, sync, back porch.
- de = (h in active) and (v in active).
- hsync is active in the h sync region on every line.
- vsync is active for whole lines in the v sync region.
- A line is a "pre-line" when the next line is active: v == V_TOTAL-1, or v < V_ACTIVE-1.
- Preamble: on a pre-line with h in [H_TOTAL-PRE_LEN-GB_LEN, H_TOTAL-GB_LEN), ctrl = 4'b0001.
- Guard band: on a pre-line with h in [H_TOTAL-GB_LEN, H_TOTAL), guard = 1 and ctrl = 0.
- pix_req at a position equals de at the following position.
- frame_start = (h==0 && v==0).
- FSM:
  - IDLE: counters hold; all outputs at inactive level. If i_enable=1, load h=0, v=V_TOTAL-1 and go to RUN.
  - RUN: counters advance every cycle. If i_enable=0, go to DRAIN.
  - DRAIN: counters advance. If i_enable=1, return to RUN with no counter disturbance. At h==H_TOTAL-1, v==V_TOTAL-2, go to IDLE. Restart then resumes seamlessly at v=V_TOTAL-1.
- Entering RUN at v=V_TOTAL-1 guarantees that the first active line is preceded by a full preamble and guard band.
- The sequencer never truncates a frame.

## Timing
- All outputs are registered. Outputs in cycle n+1 reflect the counter position held in cycle n, i.e. a fixed 1-cycle output latency from position.
- Relative to position, every output has the same latency, so all outputs stay mutually aligned.
- o_pix_req leads o_de by exactly 1 cycle. It is asserted on the last cycle of each pre-line (coinciding with the final guard cycle) and deasserts 1 cycle before o_de falls.
- o_x/o_y may hold any value when o_de=0.
- Reset (i_reset_n=0, asynchronous, at any point including mid-frame):
  - FSM goes to IDLE; h=0, v=0.
  - o_hsync=~HS_POL, o_vsync=~VS_POL.
  - o_de, o_guard, o_pix_req, o_frame_start, o_busy = 0.
  - o_ctrl=0, o_x=0, o_y=0.
- Release of reset is sampled on the next rising edge. The first RUN position requires i_enable=1 to be seen on a clock edge after release.
- Simultaneous events:
  - i_enable falling and rising within DRAIN: stay in the frame with no gap.
  - i_enable=0 on the exact cycle DRAIN reaches its end position: go to IDLE.

## Test plan
- Small config for all scenarios: H_ACTIVE=16, H_FP=2, H_SYNC=3, H_BP=12, V_ACTIVE=4, V_FP=1, V_SYNC=2, V_BP=2. This gives H_TOTAL=33, V_TOTAL=9.
- Reset values: hold i_reset_n=0 mid-RUN → all outputs immediately take their reset levels (o_hsync=0 for HS_POL=1, o_de=0, o_ctrl=0, o_busy=0), asynchronously before the next edge.
- Frame geometry: enable for 2 frames → per frame exactly 64 o_de cycles and 4 lines of 16. o_hsync high 3 cycles per 33 cycles. o_vsync high for 66 consecutive cycles. o_frame_start once per 297 cycles.
- Preamble/guard: on each line preceding an active line → o_ctrl=4'b0001 for 8 cycles, then o_guard=1 for 2 cycles, then o_de=1 with o_x=0. No preamble or guard on other lines.
- Pixel request: every o_pix_req rise is exactly 1 cycle before o_de rises, and every fall exactly 1 cycle before o_de falls. Counts are equal per frame (64).
- Clean stop/restart: drop i_enable mid active line 2 → the frame completes. o_busy falls after v=7, h=32. Re-enable 10 cycles later → preamble and guard present before the next o_frame_start.
- Abort stop: drop, then re-raise i_enable during DRAIN → no gap in the h/v sequence; o_busy stays 1 throughout.
